// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_pkg
//  Description : Shared types and helpers for the APB completer: FSM state
//                encoding, default bus widths and the address-window decode
//                check (alignment and range).
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } apb_state_e;

    // Returns 1 when a byte address is misaligned or outside
    // [base, base + window). Operands are widened to 64 bits so the upper
    // bound cannot wrap for any address width up to 63 bits.
    function automatic logic apb_decode_err(
        input logic [63:0] addr,
        input logic [63:0] base,
        input logic [63:0] window
    );
        return (addr[1:0] != 2'b00) || (addr < base) || (addr >= base + window);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : apb_slave_if
//  Description : APB bus bundle between a requester and a completer.
//                master modport : drives paddr/pwdata/pwrite/pselx/penable
//                slave  modport : drives prdata/pready/pslverr
//  Revision    : 1.0 - initial release
// ============================================================================
interface apb_slave_if
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_W,
    parameter int DATA_WIDTH = APB_DATA_W
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pwrite;
    logic                  pselx;
    logic                  penable;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output paddr, pwdata, pwrite, pselx, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwdata, pwrite, pselx, penable,
        output prdata, pready, pslverr
    );

endinterface
`default_nettype wire

// File: rtl/apb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : apb_regfile
//  Description : DEPTH x DATA_WIDTH register file, one synchronous write port,
//                one asynchronous read port, synchronous clear on rst.
//  Ports       : clk, rst        - clock / sync active-high clear
//                i_we, i_waddr,
//                i_wdata         - write port
//                i_raddr, o_rdata - read port
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_regfile
    import apb_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = APB_DATA_W,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_we,
    input  wire logic [IDX_W-1:0]      i_waddr,
    input  wire logic [DATA_WIDTH-1:0] i_wdata,
    input  wire logic [IDX_W-1:0]      i_raddr,
    output logic      [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/apb_slave.sv
`default_nettype none
// ============================================================================
//  Module      : apb_slave
//  Description : APB completer serving a word-addressed register file inside
//                a decoded address window, with WAIT_CYCLES wait states per
//                access and PSLVERR on misaligned / out-of-window accesses.
//  Ports       : pclk   - clock (rising edge)
//                preset - synchronous active-high reset
//                bus    - APB slave modport (paddr, pwdata, pwrite, pselx,
//                         penable in; prdata, pready, pslverr out)
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_slave
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = APB_ADDR_W,
    parameter int                    DATA_WIDTH  = APB_DATA_W,
    parameter int                    DEPTH       = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_CYCLES = 1
) (
    input  wire logic  pclk,
    input  wire logic  preset,
    apb_slave_if.slave bus
);

    localparam int         c_IDX_W        = $clog2(DEPTH);
    localparam logic [63:0] c_WINDOW_BYTES = 64'(DEPTH) * 64'd4;
    localparam logic [3:0]  c_WAIT_LOAD    = 4'(WAIT_CYCLES);

    apb_state_e              r_state;
    logic [3:0]              r_cnt;
    logic [c_IDX_W-1:0]      r_idx;
    logic                    r_write;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_prdata;
    logic                    r_pready;
    logic                    r_pslverr;

    logic                    w_setup;
    logic                    w_access;
    logic                    w_err;
    logic [c_IDX_W-1:0]      w_idx;
    logic [c_IDX_W-1:0]      w_raddr;
    logic                    w_we;
    logic [DATA_WIDTH-1:0]   w_rdata;

    assign w_setup  = bus.pselx & ~bus.penable;
    assign w_access = bus.pselx & bus.penable;
    assign w_err    = apb_decode_err(64'(bus.paddr), 64'(BASE_ADDR), c_WINDOW_BYTES);

    // BASE_ADDR is window-aligned, so subtracting it never changes the
    // word-index bits; the index can be taken straight from paddr.
    assign w_idx    = bus.paddr[c_IDX_W+1:2];

    // With zero wait states READY is entered straight from IDLE, so the read
    // must use the live address rather than the latched one.
    assign w_raddr  = (r_state == IDLE) ? w_idx : r_idx;

    assign w_we     = (r_state == READY) & w_access & r_write & ~r_err;

    apb_regfile #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (c_IDX_W)
    ) u_regfile (
        .clk     (pclk),
        .rst     (preset),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_wdata (r_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_wdata   <= '0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_setup) begin
                        r_idx   <= w_idx;
                        r_write <= bus.pwrite;
                        r_wdata <= bus.pwdata;
                        r_err   <= w_err;
                        r_cnt   <= c_WAIT_LOAD;
                        if (WAIT_CYCLES == 0) begin
                            r_state   <= READY;
                            r_pready  <= 1'b1;
                            r_pslverr <= w_err;
                            r_prdata  <= (w_err | bus.pwrite) ? '0 : w_rdata;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    if (!bus.pselx) begin
                        r_state <= IDLE;
                    end else if (bus.penable) begin
                        if (r_cnt == 4'd1) begin
                            r_state   <= READY;
                            r_pready  <= 1'b1;
                            r_pslverr <= r_err;
                            r_prdata  <= (r_err | r_write) ? '0 : w_rdata;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end
                end

                READY: begin
                    // Leave on completion or on abort; the write itself is
                    // committed by the register file through w_we.
                    if (!bus.pselx || bus.penable) begin
                        r_state   <= IDLE;
                        r_pready  <= 1'b0;
                        r_pslverr <= 1'b0;
                        r_prdata  <= '0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.prdata  = r_prdata;
    assign bus.pready  = r_pready;
    assign bus.pslverr = r_pslverr;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_slave
//  Description : Self-checking bench for apb_slave. Three instances with
//                different wait-state counts / base addresses share one
//                driven bus; the selected instance gets pselx. Expected
//                responses are queued at issue time and checked by a
//                separate monitor when pready appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_slave;

    typedef struct {
        int          dut;
        int          cyc;
        logic        err;
        logic        chk_data;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst;
    int          cyc;
    int          n_checks;
    int          n_fail;

    logic        r_psel;
    logic        r_penable;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;
    logic        r_pwrite;
    int          r_sel;

    exp_t        sb_q[$];
    logic [31:0] mem [3][16];

    apb_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if0 ();
    apb_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if1 ();
    apb_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if2 ();

    assign if0.paddr = r_paddr;  assign if0.pwdata = r_pwdata;  assign if0.pwrite = r_pwrite;
    assign if1.paddr = r_paddr;  assign if1.pwdata = r_pwdata;  assign if1.pwrite = r_pwrite;
    assign if2.paddr = r_paddr;  assign if2.pwdata = r_pwdata;  assign if2.pwrite = r_pwrite;
    assign if0.penable = r_penable;
    assign if1.penable = r_penable;
    assign if2.penable = r_penable;
    assign if0.pselx = r_psel && (r_sel == 0);
    assign if1.pselx = r_psel && (r_sel == 1);
    assign if2.pselx = r_psel && (r_sel == 2);

    logic [2:0]  w_pready;
    logic [2:0]  w_pslverr;
    logic [31:0] w_prdata [3];
    assign w_pready  = {if2.pready,  if1.pready,  if0.pready};
    assign w_pslverr = {if2.pslverr, if1.pslverr, if0.pslverr};
    assign w_prdata[0] = if0.prdata;
    assign w_prdata[1] = if1.prdata;
    assign w_prdata[2] = if2.prdata;

    apb_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16),
                .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0))
        u_dut0 (.pclk(clk), .preset(rst), .bus(if0.slave));
    apb_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16),
                .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(1))
        u_dut1 (.pclk(clk), .preset(rst), .bus(if1.slave));
    apb_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16),
                .BASE_ADDR(32'h0000_0100), .WAIT_CYCLES(3))
        u_dut2 (.pclk(clk), .preset(rst), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wait_of(input int d);
        case (d)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 2) ? 32'h0000_0100 : 32'h0000_0000;
    endfunction

    function automatic logic model_err(input int d, input logic [31:0] a);
        return (a % 4 != 0) || (a < base_of(d)) || (a >= base_of(d) + 64);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every pready must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("pslverr_without_pready[%0d]", k),
                  32'(w_pslverr[k] & ~w_pready[k]), 32'd0);
            if (w_pready[k]) begin
                if (sb_q.size() == 0) begin
                    check($sformatf("unexpected_pready[%0d]", k), 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("ready_dut", 32'(k), 32'(e.dut));
                    check("ready_cycle", 32'(cyc), 32'(e.cyc));
                    check("pslverr", 32'(w_pslverr[k]), 32'(e.err));
                    if (e.chk_data) check("prdata", w_prdata[k], e.rdata);
                end
            end
        end
    end

    task automatic idle(input int n);
        r_psel    = 1'b0;
        r_penable = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // abort_at = 0: complete normally; abort_at = n: drop pselx in access cycle n.
    task automatic do_xfer(input int d, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input int abort_at);
        exp_t e;
        logic err;
        int   idx;
        logic done;
        err        = model_err(d, addr);
        idx        = int'((addr - base_of(d)) / 4) & 15;
        e.dut      = d;
        e.cyc      = cyc + 1 + wait_of(d);
        e.err      = err;
        e.chk_data = !wr;
        e.rdata    = (wr || err) ? 32'd0 : mem[d][idx];
        if (abort_at == 0) begin
            sb_q.push_back(e);
            if (wr && !err) mem[d][idx] = data;
        end
        r_sel     = d;
        r_psel    = 1'b1;
        r_penable = 1'b0;
        r_paddr   = addr;
        r_pwrite  = wr;
        r_pwdata  = data;
        @(posedge clk);
        #1;
        r_penable = 1'b1;
        if (abort_at > 0) begin
            repeat (abort_at - 1) begin
                @(posedge clk);
                #1;
            end
            r_psel    = 1'b0;
            r_penable = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            done = 1'b0;
            for (int k = 0; k < 40 && !done; k++) begin
                @(negedge clk);
                if (w_pready[d]) done = 1'b1;
                @(posedge clk);
                #1;
            end
            if (!done) begin
                check("pready_timeout", 32'd0, 32'd1);
                r_psel    = 1'b0;
                r_penable = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] v0;
        logic [31:0] v1;
        int          d;
        int          r;
        cyc       = 0;
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        r_psel    = 1'b0;
        r_penable = 1'b0;
        r_paddr   = '0;
        r_pwdata  = '0;
        r_pwrite  = 1'b0;
        r_sel     = 0;
        for (int i = 0; i < 3; i++) for (int j = 0; j < 16; j++) mem[i][j] = '0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("reset_pready",  32'(w_pready[k]),  32'd0);
            check("reset_pslverr", 32'(w_pslverr[k]), 32'd0);
            check("reset_prdata",  w_prdata[k],       32'd0);
        end

        // One wait state: write then read the same word.
        do_xfer(1, 1'b1, 32'h04, 32'd16, 0);
        do_xfer(1, 1'b0, 32'h04, 32'd0, 0);
        idle(2);

        // Zero wait states: back-to-back at both ends of the window.
        v0 = $urandom;
        v1 = $urandom;
        do_xfer(0, 1'b1, 32'h00, v0, 0);
        do_xfer(0, 1'b1, 32'h3C, v1, 0);
        do_xfer(0, 1'b0, 32'h00, 32'd0, 0);
        do_xfer(0, 1'b0, 32'h3C, 32'd0, 0);
        idle(1);

        // Decode errors leave memory untouched.
        do_xfer(0, 1'b1, 32'h40, 32'hDEAD_BEEF, 0);
        do_xfer(0, 1'b1, 32'h02, 32'hCAFE_F00D, 0);
        do_xfer(0, 1'b0, 32'h00, 32'd0, 0);
        do_xfer(0, 1'b0, 32'h40, 32'd0, 0);
        do_xfer(2, 1'b0, 32'hFC, 32'd0, 0);
        idle(1);

        // Three wait states with an abort in the second access cycle.
        do_xfer(2, 1'b1, 32'h104, 32'h1234_5678, 0);
        idle(1);
        do_xfer(2, 1'b1, 32'h104, 32'h8765_4321, 2);
        idle(2);
        do_xfer(2, 1'b0, 32'h104, 32'd0, 0);
        idle(1);

        // Randomised mix across all three instances.
        for (int n = 0; n < 80; n++) begin
            d = $urandom_range(0, 2);
            r = $urandom_range(0, 9);
            if (r < 7)       a = base_of(d) + 4 * $urandom_range(0, 15);
            else if (r == 7) a = base_of(d) + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
            else if (r == 8) a = base_of(d) + 64 + 4 * $urandom_range(0, 15);
            else             a = (d == 2) ? 32'hF0 : 32'h1000;
            do_xfer(d, 1'($urandom_range(0, 1)), a, $urandom, 0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(1);

        // Reset pulsed while a write sits in the wait state.
        do_xfer(1, 1'b1, 32'h04, 32'hAAAA_5555, 0);
        r_sel     = 2;
        r_psel    = 1'b1;
        r_penable = 1'b0;
        r_paddr   = 32'h104;
        r_pwrite  = 1'b1;
        r_pwdata  = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        r_penable = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        r_psel    = 1'b0;
        r_penable = 1'b0;
        for (int i = 0; i < 3; i++) for (int j = 0; j < 16; j++) mem[i][j] = '0;
        check("rst_pready",  32'(w_pready[2]),  32'd0);
        check("rst_pslverr", 32'(w_pslverr[2]), 32'd0);
        check("rst_prdata",  w_prdata[2],       32'd0);
        idle(4);
        do_xfer(2, 1'b0, 32'h104, 32'd0, 0);
        do_xfer(1, 1'b0, 32'h04, 32'd0, 0);
        idle(3);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_slave.md
# apb_slave

APB completer that terminates transfers issued by the team's `apb` requester and serves them from an internal word-addressed register file. It decodes a configurable address window, inserts a programmable number of wait states via PREADY, and flags illegal accesses with PSLVERR. It sits directly on the requester's PSELx/PENABLE bus as the peripheral endpoint.

## Interface
- ADDR_WIDTH, 32: PADDR width.
- DATA_WIDTH, 32: PWDATA/PRDATA width.
- DEPTH, 16: number of words in the register file (power of 2, ≥2).
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be DEPTH*4-aligned.
- WAIT_CYCLES, 1: wait states inserted in every access phase (0–15).
- PCLK  in  1  clock; all logic on its rising edge.
- PRESET  in  1  reset; synchronous, active-high.
- PADDR  in  ADDR_WIDTH  byte address, sampled in the setup phase.
- PWDATA  in  DATA_WIDTH  write data, sampled in the setup phase.
- PWRITE  in  1  1 = write, 0 = read.
- PSELx  in  1  slave select.
- PENABLE  in  1  access-phase indicator.
- PRDATA  out  DATA_WIDTH  read data, valid only while PREADY=1.
- PREADY  out  1  transfer completes on a cycle with PSELx & PENABLE & PREADY.
- PSLVERR  out  1  error response, valid only while PREADY=1.

## Operation
- FSM states: IDLE, WAIT, READY.
- IDLE: on PSELx=1, PENABLE=0 (setup), latch PADDR, PWRITE, PWDATA and the decode result. Load cnt=WAIT_CYCLES. Next state is READY if WAIT_CYCLES=0, else WAIT. PSELx=1 with PENABLE=1 in IDLE (no setup seen) is ignored.
- WAIT: while PSELx & PENABLE, go to READY when cnt=1, else decrement cnt.
- READY: PREADY=1. On the completion cycle, commit the write if it is legal, then return to IDLE.
- PSELx=0 in WAIT or READY aborts the transfer: go to IDLE, no write, outputs return to 0.
- Decode error: PADDR[1:0]≠0, PADDR<BASE_ADDR, or PADDR≥BASE_ADDR+DEPTH*4. An erroring transfer asserts PSLVERR with PREADY, never writes, and reads return 0.
- Word index: (PADDR−BASE_ADDR)[log2(DEPTH)+1:2].
- Read data is registered. It is loaded from the register file on the edge that enters READY and cleared to 0 on the edge that leaves READY.
- A write commits on the completion edge. A read of the same word in the next transfer returns the new value.

## Timing
- Reset values: PRDATA=0, PREADY=0, PSLVERR=0, state=IDLE, cnt=0, all register-file words=0.
- Setup in cycle T0 gives PREADY=1 in cycle T0+1+WAIT_CYCLES. The access phase lasts WAIT_CYCLES+1 cycles.
- PREADY is high for exactly one cycle per transfer. PSLVERR is never high without PREADY.
- Back-to-back: a setup in the cycle right after completion is accepted from IDLE, with no dead cycle.
- PRESET=1 in any state sends the block to IDLE on that edge, drops any pending write, and clears the register file. Reset overrides a simultaneous completion.

## Structure
- Package `apb_pkg`: FSM state enum (IDLE/WAIT/READY), APB_ADDR_W/APB_DATA_W defaults, and a decode helper function (range and alignment check).
- Sub-module `apb_regfile`: DEPTH×DATA_WIDTH array with one synchronous write port, one read port, and synchronous clear on PRESET.
- The top level holds the FSM, wait counter, request latches and output registers.

## Test plan
- Reset, then WAIT_CYCLES=1: write 32'd16 to 0x04, then read 0x04 → write PREADY one cycle after PENABLE rises; read PRDATA=16; PSLVERR=0 throughout.
- WAIT_CYCLES=0: back-to-back writes to 0x00 and 0x3C, then reads of both → each PREADY=1 in the first access cycle; data returned correctly; no idle cycles between transfers.
- Write to 0x40 (out of range), then 0x02 (misaligned) → PSLVERR=1 with PREADY; a read of 0x00 afterwards shows the old value; a read of 0x40 returns PRDATA=0 with PSLVERR=1.
- WAIT_CYCLES=3 write, with PSELx dropped in the second access cycle → PREADY never rises; a later read of that address shows the old value.
- PRESET=1 pulsed during a WAIT-state write, then a read of 0x04 → PREADY/PSLVERR/PRDATA=0 at the reset edge; the read returns 0.
